// File: rtl/tt_mult_pkg.sv
// Shared widths and the round-robin pick helper for the shared multiplier arbiter.
package tt_mult_pkg;

    localparam int unsigned N_DEF     = 23;
    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned RR_MAX    = 32;
    localparam int unsigned RR_IW     = $clog2(RR_MAX);

    // Product width for an N x N unsigned multiply.
    function automatic int unsigned prod_w(input int unsigned n);
        return 2 * n;
    endfunction

    // Tag width needed to name one of n requesters (at least one bit).
    function automatic int unsigned tag_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TAG_W_DEF = tag_w(NREQ_DEF);

    // One-hot grant: first set bit of mask searching ptr, ptr+1, ... modulo n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] mask,
        input int unsigned       ptr,
        input int unsigned       n
    );
        logic [RR_MAX-1:0] gnt;
        logic              found;
        int unsigned       sum;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            sum = ptr + k;
            if (sum >= n) begin
                sum = sum - n;
            end
            if (!found && (k < n) && mask[RR_IW'(sum)]) begin
                gnt[RR_IW'(sum)] = 1'b1;
                found            = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared multiplier arbiter.
interface mult_share_arbiter_if
    import tt_mult_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF
) ();

    localparam int unsigned P = prod_w(N);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*P-1:0] rsp_p;

    // Requester side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p
    );

endinterface

// File: rtl/mult_pipe.sv
// Tagged unsigned N x N multiplier: product registered in stage 0, then LAT-1 delay stages.
module mult_pipe
    import tt_mult_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned LAT = 1,
    parameter int unsigned TW  = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic [TW-1:0]      in_tag,
    output logic               out_valid,
    output logic [2*N-1:0]     out_p,
    output logic [TW-1:0]      out_tag
);

    localparam int unsigned P = prod_w(N);

    logic [LAT-1:0] vld_q, vld_d;
    logic [P-1:0]   p_q   [LAT];
    logic [P-1:0]   p_d   [LAT];
    logic [TW-1:0]  tag_q [LAT];
    logic [TW-1:0]  tag_d [LAT];

    // Next-stage values; data only moves when the stage behind it is valid.
    always_comb begin
        vld_d    = '0;
        p_d      = p_q;
        tag_d    = tag_q;
        vld_d[0] = in_valid;
        if (in_valid) begin
            p_d[0]   = P'(in_a) * P'(in_b);
            tag_d[0] = in_tag;
        end
        for (int unsigned s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
                p_d[s]   = p_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
        end
    end

    // Stage valids; only these need reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage payloads.
    always_ff @(posedge clk) begin
        p_q   <= p_d;
        tag_q <= tag_d;
    end

    assign out_valid = vld_q[LAT-1];
    assign out_p     = p_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier pipe between NREQ requesters, one op in flight each.
module mult_share_arbiter
    import tt_mult_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus,
    output logic                idle
);

    localparam int unsigned P  = prod_w(N);
    localparam int unsigned TW = tag_w(NREQ);

    logic [NREQ-1:0] busy_q, busy_d;
    logic [TW-1:0]   ptr_q, ptr_d;
    logic            run_q;
    logic [NREQ-1:0] hold_vld_q, hold_vld_d;
    logic [P-1:0]    hold_p_q [NREQ];
    logic [P-1:0]    hold_p_d [NREQ];

    logic [NREQ-1:0] elig, grant, acc;
    logic [NREQ-1:0] pipe_hit, rsp_vld, rsp_hs;
    logic            iss_vld;
    logic [N-1:0]    iss_a, iss_b;
    logic [TW-1:0]   iss_tag;
    logic            pipe_vld;
    logic [P-1:0]    pipe_p;
    logic [TW-1:0]   pipe_tag;

    // Grant the first idle, valid requester from the rr pointer; mux its operands into the pipe.
    always_comb begin
        elig          = bus.req_valid & ~busy_q & {NREQ{run_q}};
        grant         = NREQ'(rr_pick(RR_MAX'(elig), 32'(ptr_q), NREQ));
        bus.req_ready = grant;
        acc           = grant & bus.req_valid;
        iss_vld       = |acc;
        iss_a         = '0;
        iss_b         = '0;
        iss_tag       = '0;
        ptr_d         = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                iss_a   = bus.req_a[i*N +: N];
                iss_b   = bus.req_b[i*N +: N];
                iss_tag = TW'(i);
                ptr_d   = (i == NREQ - 1) ? '0 : TW'(i + 1);
            end
        end
    end

    mult_pipe #(
        .N   (N),
        .LAT (LAT),
        .TW  (TW)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iss_vld),
        .in_a      (iss_a),
        .in_b      (iss_b),
        .in_tag    (iss_tag),
        .out_valid (pipe_vld),
        .out_p     (pipe_p),
        .out_tag   (pipe_tag)
    );

    // Route pipe output to its requester; park it in the holding register unless consumed now.
    always_comb begin
        bus.rsp_p  = '0;
        hold_vld_d = hold_vld_q;
        hold_p_d   = hold_p_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pipe_hit[i]           = pipe_vld & (pipe_tag == TW'(i));
            rsp_vld[i]            = hold_vld_q[i] | pipe_hit[i];
            rsp_hs[i]             = rsp_vld[i] & bus.rsp_ready[i];
            bus.rsp_p[i*P +: P]   = pipe_hit[i] ? pipe_p : hold_p_q[i];
            if (pipe_hit[i]) begin
                hold_p_d[i]   = pipe_p;
                hold_vld_d[i] = ~bus.rsp_ready[i];
            end else if (rsp_hs[i]) begin
                hold_vld_d[i] = 1'b0;
            end
        end
        bus.rsp_valid = rsp_vld;
        busy_d        = (busy_q | acc) & ~rsp_hs;
        idle          = ~|busy_q;
    end

    // Arbiter state, busy vector and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            run_q      <= 1'b0;
            hold_vld_q <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                hold_p_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            run_q      <= 1'b1;
            hold_vld_q <= hold_vld_d;
            hold_p_q   <= hold_p_d;
        end
    end

endmodule
